// File: rtl/sum_seq.sv
// sum_seq: sequential multi-operand adder.
// Accumulates up to DEPTH operands per group, or fewer if in_last closes the group early.
// The full-precision result is presented over a valid/ready handshake.
// Define SUM_SEQ_SIGNED_EN to treat operands as two's complement and sign-extend them.
// Without it, operands are unsigned and zero-extended.
module sum_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned RES_W = WIDTH + $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [0:0] {StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;

    logic [RES_W-1:0] op_ext;
    logic [RES_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_hs;
    logic             close_grp;

`ifdef SUM_SEQ_SIGNED_EN
    assign op_ext = {{(RES_W - WIDTH){in_data[WIDTH-1]}}, in_data};
`else
    assign op_ext = {{(RES_W - WIDTH){1'b0}}, in_data};
`endif

    // Handshake qualifiers are pure state decodes, so nothing here depends on out_ready.
    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StDone);
    assign out_res   = res_q;
    assign out_cnt   = ocnt_q;

    assign acc_sum   = acc_q + op_ext;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign in_hs     = in_valid && in_ready;
    assign close_grp = in_hs && ((cnt_inc == CNT_W'(DEPTH)) || in_last);

    // Next-state: accumulate in StAcc, publish the result on the closing operand, hold in StDone.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ocnt_d  = ocnt_q;
        unique case (state_q)
            StAcc: begin
                if (in_hs) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (close_grp) begin
                        res_d   = acc_sum;
                        ocnt_d  = cnt_inc;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAcc;
                end
            end
        endcase
    end

    // State registers; reset discards any partial group and clears the published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ocnt_q  <= ocnt_d;
        end
    end

endmodule

// File: tb/tb_sum_seq.sv
// Bench for sum_seq: directed groups with literal expectations, plus a per-cycle compare
// against a group-level model (operands stored, summed when the group closes).
module tb_sum_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RES_W = WIDTH + $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [RES_W-1:0] out_res;
    logic [CNT_W-1:0] out_cnt;

    int n_vec = 0;
    int n_err = 0;

    sum_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    function automatic int op_val(input logic [WIDTH-1:0] d);
`ifdef SUM_SEQ_SIGNED_EN
        return int'($signed(d));
`else
        return int'(d);
`endif
    endfunction

    function automatic int res_val(input logic [RES_W-1:0] r);
`ifdef SUM_SEQ_SIGNED_EN
        return int'($signed(r));
`else
        return int'(r);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operands of the open group kept in an array, summed when the group closes.
    int grp_ops[DEPTH];
    int m_n    = 0;
    bit m_busy = 1'b0;
    int m_res  = 0;
    int m_cnt  = 0;

    function automatic int grp_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += grp_ops[i];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_busy <= 1'b0;
            m_res  <= 0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                if (m_n + 1 == int'(DEPTH) || in_last) begin
                    m_res  <= grp_sum(m_n) + op_val(in_data);
                    m_cnt  <= m_n + 1;
                    m_n    <= 0;
                    m_busy <= 1'b1;
                end else begin
                    grp_ops[m_n] <= op_val(in_data);
                    m_n          <= m_n + 1;
                end
            end
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Compare DUT to model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("model in_ready", int'(in_ready), int'(!m_busy));
        chk("model out_valid", int'(out_valid), int'(m_busy));
        chk("model out_res", res_val(out_res), m_res);
        chk("model out_cnt", int'(out_cnt), m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        bit took = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 20 && !took; i++) begin
            took = in_ready;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send timeout: operand %0d not accepted", d);
        end
    endtask

    task automatic expect_res(input int exp_res, input int exp_cnt);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("lit out_valid", int'(out_valid), 1);
        chk("lit out_res", res_val(out_res), exp_res);
        chk("lit out_cnt", int'(out_cnt), exp_cnt);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step();
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_res", int'(out_res), 0);
        chk("reset out_cnt", int'(out_cnt), 0);
        step();
        rst_n = 1'b1;
        step();

        // Zeros fill a group to DEPTH; DONE lasts one cycle with out_ready high.
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0);
        expect_res(0, 4);
        step();
        chk("zeros out_valid one cycle", int'(out_valid), 0);

`ifndef SUM_SEQ_SIGNED_EN
        // Full-scale unsigned group, back-to-back.
        for (int i = 0; i < 4; i++) send(8'd255, 1'b0);
        expect_res(1020, 4);
        chk("max in_ready low", int'(in_ready), 0);
        step();
        chk("max in_ready back", int'(in_ready), 1);
`endif

        // Early close, then backpressure on the next result.
        send(8'd45, 1'b0);
        send(8'd37, 1'b1);
        expect_res(82, 2);
        step();
        out_ready = 1'b0;
        send(8'd103, 1'b0);
        send(8'd89, 1'b1);
        expect_res(192, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp out_res", res_val(out_res), 192);
            chk("bp in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp released in_ready", int'(in_ready), 1);

        // Idle cycles mid-group, with a stray in_last while in_valid is low.
        send(8'd56, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_last = (i == 2);
            step();
        end
        in_last = 1'b0;
        send(8'd12, 1'b1);
        expect_res(68, 2);
        step();

        // Reset mid-group discards the partial sum.
        send(8'd100, 1'b0);
        send(8'd100, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst out_res", int'(out_res), 0);
        chk("midrst out_cnt", int'(out_cnt), 0);
        rst_n = 1'b1;
        step();
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        expect_res(10, 4);
        step();

`ifdef SUM_SEQ_SIGNED_EN
        for (int i = 0; i < 4; i++) send(8'h80, 1'b0);
        expect_res(-512, 4);
        chk("neg raw bits", int'(out_res), 'h200);
        step();
        for (int i = 0; i < 4; i++) send(8'd127, 1'b0);
        expect_res(508, 4);
        step();
        send(8'hFB, 1'b0);
        send(8'd3, 1'b1);
        expect_res(-2, 2);
        chk("mixed raw bits", int'(out_res), 'h3FE);
        step();
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
